// File: rtl/bcd_stopwatch_counter_if.sv
// bcd_stopwatch_counter_if: control/count bundle for the BCD stopwatch; LAP_CAPTURE_EN adds lap capture signals
interface bcd_stopwatch_counter_if #(parameter int DIGITS = 4);
  logic tick, start_stop, clear, load, down, running, expired, terminal;
  logic [4*DIGITS-1:0] load_value, digits;
`ifdef LAP_CAPTURE_EN
  logic lap, lap_valid;
  logic [4*DIGITS-1:0] lap_digits;
  modport master(output tick, start_stop, clear, load, load_value, down, lap,
                 input digits, running, expired, terminal, lap_digits, lap_valid);
  modport slave(input tick, start_stop, clear, load, load_value, down, lap,
                output digits, running, expired, terminal, lap_digits, lap_valid);
`else
  modport master(output tick, start_stop, clear, load, load_value, down,
                 input digits, running, expired, terminal);
  modport slave(input tick, start_stop, clear, load, load_value, down,
                output digits, running, expired, terminal);
`endif
endinterface

// File: rtl/bcd_stopwatch_counter.sv
// bcd_stopwatch_counter: up/down BCD stopwatch with saturate/wrap terminal FSM; LAP_CAPTURE_EN adds lap capture
module bcd_stopwatch_counter #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b0
) (
  input logic clk,
  input logic reset_n,
  bcd_stopwatch_counter_if.slave bus
);
  localparam int W = 4*DIGITS;
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};
  typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;
  state_t state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt, stepped, clamped, lim;
  logic prev, start_edge, at_limit, term_nxt, carry, running, expired, terminal;
  assign start_edge = bus.start_stop & ~prev;
  assign lim = bus.down ? '0 : NINES;
  assign at_limit = cnt == lim;
  always_comb begin
    stepped = cnt;
    clamped = '0;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      stepped[4*i+:4] = !carry ? cnt[4*i+:4]
                      : bus.down ? (cnt[4*i+:4] == 4'd0 ? 4'd9 : cnt[4*i+:4] - 4'd1)
                      : (cnt[4*i+:4] == 4'd9 ? 4'd0 : cnt[4*i+:4] + 4'd1);
      carry = carry & (cnt[4*i+:4] == (bus.down ? 4'd0 : 4'd9));
      clamped[4*i+:4] = bus.load_value[4*i+:4] > 4'd9 ? 4'd9 : bus.load_value[4*i+:4];
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    term_nxt = 1'b0;
    if (bus.clear) begin
      state_nxt = STOPPED;
      cnt_nxt = '0;
    end else if (bus.load) begin
      state_nxt = STOPPED;
      cnt_nxt = clamped;
    end else if (start_edge) begin
      state_nxt = state == STOPPED ? RUNNING : STOPPED;
    end else if (bus.tick && state == RUNNING) begin
      // saturating mode holds at the limit; wrap mode lets the ripple carry roll over
      term_nxt = WRAP ? at_limit : (at_limit || stepped == lim);
      cnt_nxt = (!WRAP && at_limit) ? cnt : stepped;
      state_nxt = (!WRAP && term_nxt) ? EXPIRED : RUNNING;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= STOPPED;
      cnt <= '0;
      prev <= 1'b0;
      running <= 1'b0;
      expired <= 1'b0;
      terminal <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      prev <= bus.start_stop;
      running <= state_nxt == RUNNING;
      expired <= state_nxt == EXPIRED;
      terminal <= term_nxt;
    end
  assign bus.digits = cnt;
  assign bus.running = running;
  assign bus.expired = expired;
  assign bus.terminal = terminal;
`ifdef LAP_CAPTURE_EN
  logic lap_prev, lap_valid;
  logic [W-1:0] lap_digits;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      lap_prev <= 1'b0;
      lap_digits <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_prev <= bus.lap;
      if (bus.clear) begin
        lap_digits <= '0;
        lap_valid <= 1'b0;
      end else if (bus.lap && !lap_prev) begin
        lap_digits <= cnt;
        lap_valid <= 1'b1;
      end
    end
  assign bus.lap_digits = lap_digits;
  assign bus.lap_valid = lap_valid;
`endif
endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// tb_bcd_stopwatch_counter: saturating and wrapping instances driven in lockstep against an integer-valued model
module tb_bcd_stopwatch_counter;
  localparam int DIGITS = 4;
  localparam int unsigned MAXV = 9999;
  logic clk = 1'b0, reset_n = 1'b0;
  logic tick = 1'b0, start_stop = 1'b0, clear = 1'b0, load = 1'b0, down = 1'b0;
  logic [15:0] load_value = '0;
  int total = 0, bad = 0;
  int unsigned m_v[2];
  int m_st[2];
  bit m_term[2];
  bit m_prev;
  logic [37:0] act;
  bcd_stopwatch_counter_if #(.DIGITS(DIGITS)) b0();
  bcd_stopwatch_counter_if #(.DIGITS(DIGITS)) b1();
  bcd_stopwatch_counter #(.DIGITS(DIGITS), .WRAP(1'b0)) u0(.clk(clk), .reset_n(reset_n), .bus(b0));
  bcd_stopwatch_counter #(.DIGITS(DIGITS), .WRAP(1'b1)) u1(.clk(clk), .reset_n(reset_n), .bus(b1));
  assign b0.tick = tick;
  assign b0.start_stop = start_stop;
  assign b0.clear = clear;
  assign b0.load = load;
  assign b0.down = down;
  assign b0.load_value = load_value;
  assign b1.tick = tick;
  assign b1.start_stop = start_stop;
  assign b1.clear = clear;
  assign b1.load = load;
  assign b1.down = down;
  assign b1.load_value = load_value;
`ifdef LAP_CAPTURE_EN
  assign b0.lap = 1'b0;
  assign b1.lap = 1'b0;
`endif
  assign act = {b0.digits, b0.running, b0.expired, b0.terminal, b1.digits, b1.running, b1.expired, b1.terminal};
  always #5 clk = ~clk;
  function automatic int unsigned bcd2int(logic [15:0] b);
    int unsigned v = 0;
    for (int i = DIGITS-1; i >= 0; i--) v = v*10 + ((b[4*i+:4] > 4'd9) ? 32'd9 : int'(b[4*i+:4]));
    return v;
  endfunction
  function automatic logic [15:0] int2bcd(int unsigned v);
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic logic [37:0] expv();
    return {int2bcd(m_v[0]), m_st[0] == 1, m_st[0] == 2, m_term[0],
            int2bcd(m_v[1]), m_st[1] == 1, m_st[1] == 2, m_term[1]};
  endfunction
  function automatic void model_reset();
    for (int w = 0; w < 2; w++) begin
      m_v[w] = 0;
      m_st[w] = 0;
      m_term[w] = 0;
    end
    m_prev = 0;
  endfunction
  // states: 0 stopped, 1 running, 2 expired; index 0 saturates, index 1 wraps
  function automatic void model_step();
    bit se = start_stop && !m_prev;
    int unsigned lim = down ? 0 : MAXV;
    for (int w = 0; w < 2; w++) begin
      m_term[w] = 0;
      if (clear) begin
        m_v[w] = 0;
        m_st[w] = 0;
      end else if (load) begin
        m_v[w] = bcd2int(load_value);
        m_st[w] = 0;
      end else if (se) begin
        m_st[w] = m_st[w] == 0 ? 1 : 0;
      end else if (tick && m_st[w] == 1) begin
        if (m_v[w] == lim) begin
          m_term[w] = 1;
          if (w == 1) m_v[w] = down ? MAXV : 0;
          else m_st[w] = 2;
        end else begin
          m_v[w] = down ? m_v[w] - 1 : m_v[w] + 1;
          if (w == 0 && m_v[w] == lim) begin
            m_term[w] = 1;
            m_st[w] = 2;
          end
        end
      end
    end
    m_prev = start_stop;
  endfunction
  task automatic cycle();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask
  task automatic set_in(bit t, bit s, bit c, bit l, bit d, logic [15:0] lv);
    tick = t;
    start_stop = s;
    clear = c;
    load = l;
    down = d;
    load_value = lv;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 16'h0);
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (act !== 38'h0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", act, 38'h0);
    end
    reset_n = 1'b1;
    cycle();
    total++;
    if (act !== expv()) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", act, expv());
    end
  endtask
  task automatic test_load_clamp();
    set_in(0, 0, 0, 1, 0, 16'hA5C3);
    cycle();
    set_in(0, 0, 0, 0, 0, 16'h0);
    total++;
    if (b0.digits !== 16'h9593 || act !== expv()) begin
      bad++;
      $display("FAIL load_clamp got=%h exp=%h digits=%h", act, expv(), b0.digits);
    end
    set_in(1, 1, 1, 1, 0, 16'h1234);
    cycle();
    set_in(0, 0, 0, 0, 0, 16'h0);
    total++;
    if (b0.digits !== 16'h0000 || b0.running !== 1'b0 || act !== expv()) begin
      bad++;
      $display("FAIL clear_over_load got=%h exp=%h", act, expv());
    end
  endtask
  task automatic test_up_carry();
    set_in(0, 0, 0, 1, 0, 16'h0999);
    cycle();
    set_in(0, 1, 0, 0, 0, 16'h0);
    cycle();
    set_in(1, 0, 0, 0, 0, 16'h0);
    cycle();
    set_in(0, 0, 0, 0, 0, 16'h0);
    total++;
    if (b0.digits !== 16'h1000 || b0.running !== 1'b1 || b0.terminal !== 1'b0 || act !== expv()) begin
      bad++;
      $display("FAIL up_carry got=%h exp=%h", act, expv());
    end
  endtask
  task automatic test_down_saturate();
    logic [15:0] d_exp[3] = '{16'h0001, 16'h0000, 16'h0000};
    logic t_exp[3] = '{1'b0, 1'b1, 1'b0};
    set_in(0, 0, 0, 1, 1, 16'h0002);
    cycle();
    set_in(0, 1, 0, 0, 1, 16'h0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 0, 0, 1, 16'h0);
      cycle();
      total++;
      if (b0.digits !== d_exp[k] || b0.terminal !== t_exp[k] || act !== expv()) begin
        bad++;
        $display("FAIL down_sat_tick%0d got=%h exp=%h", k, act, expv());
      end
    end
    set_in(0, 0, 0, 0, 1, 16'h0);
    cycle();
    total++;
    if (b0.expired !== 1'b1 || b0.running !== 1'b0 || act !== expv()) begin
      bad++;
      $display("FAIL down_sat_hold got=%h exp=%h", act, expv());
    end
  endtask
  task automatic test_wrap();
    set_in(0, 0, 0, 1, 0, 16'h9999);
    cycle();
    set_in(0, 1, 0, 0, 0, 16'h0);
    cycle();
    set_in(1, 0, 0, 0, 0, 16'h0);
    cycle();
    total++;
    if (b1.digits !== 16'h0000 || b1.terminal !== 1'b1 || b1.running !== 1'b1 || act !== expv()) begin
      bad++;
      $display("FAIL wrap_roll got=%h exp=%h", act, expv());
    end
    cycle();
    total++;
    if (b1.digits !== 16'h0001 || b1.terminal !== 1'b0 || act !== expv()) begin
      bad++;
      $display("FAIL wrap_next got=%h exp=%h", act, expv());
    end
  endtask
  task automatic test_toggle();
    logic [1:0] seq[16] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                            2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00};
    set_in(0, 0, 1, 0, 0, 16'h0);
    cycle();
    for (int k = 0; k < 16; k++) begin
      set_in(seq[k][1], seq[k][0], 0, 0, 0, 16'h0);
      cycle();
      total++;
      if (act !== expv()) begin
        bad++;
        $display("FAIL toggle_step%0d got=%h exp=%h", k, act, expv());
      end
    end
    total++;
    if (b0.digits !== 16'h0001 || b0.running !== 1'b1) begin
      bad++;
      $display("FAIL toggle_final digits=%h running=%b exp=0001/1", b0.digits, b0.running);
    end
  endtask
  task automatic test_async_reset();
    set_in(0, 0, 0, 1, 0, 16'h0345);
    cycle();
    set_in(0, 1, 0, 0, 0, 16'h0);
    cycle();
    set_in(1, 0, 0, 0, 0, 16'h0);
    repeat (2) cycle();
    total++;
    if (b0.digits !== 16'h0347 || act !== expv()) begin
      bad++;
      $display("FAIL pre_reset got=%h exp=%h", act, expv());
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (act !== 38'h0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", act, 38'h0);
    end
    set_in(0, 0, 0, 0, 0, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    total++;
    if (act !== expv()) begin
      bad++;
      $display("FAIL post_reset got=%h exp=%h", act, expv());
    end
  endtask
  task automatic test_random();
    logic [15:0] lv[4] = '{16'h0000, 16'h9999, 16'h0003, 16'h9996};
    for (int n = 0; n < 800; n++) begin
      set_in($urandom_range(0, 2) != 0,
             $urandom_range(0, 7) == 0 ? !start_stop : start_stop,
             $urandom_range(0, 80) == 0,
             $urandom_range(0, 30) == 0,
             $urandom_range(0, 15) == 0 ? !down : down,
             $urandom_range(0, 1) == 0 ? 16'($urandom) : lv[$urandom_range(0, 3)]);
      cycle();
      total++;
      if (act !== expv()) begin
        bad++;
        $display("FAIL random_cycle%0d got=%h exp=%h", n, act, expv());
      end
    end
  endtask
  initial begin
    test_reset();
    test_load_clamp();
    test_up_carry();
    test_down_saturate();
    test_wrap();
    test_toggle();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
